// File: rtl/custom_ip_reg_bridge_if.sv
// APB3 bus bundle between the peripheral interconnect and custom_ip_reg_bridge.
// Latency: none, wires only.
// Backpressure: the slave stretches the access phase by holding pready low.
interface custom_ip_reg_bridge_if #(
  parameter int AW = 12
);
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [31:0]   pwdata;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/custom_ip_reg_bridge.sv
// APB3 register file driving per-channel reg2ip write strobes and capturing ip2reg read data.
// Latency: reads/errors complete one cycle after the access cycle; writes one cycle after the IP ack (or timeout).
// Backpressure: pready stays low while a write strobe waits for its acknowledge.
module custom_ip_reg_bridge #(
  parameter int NUM_CH      = 3,
  parameter int DW          = 32,
  parameter int AW          = 12,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  custom_ip_reg_bridge_if.slave  apb,
  output logic [NUM_CH*DW-1:0]   reg2ip_data_o,
  output logic [NUM_CH-1:0]      reg2ip_en_o,
  input  logic [NUM_CH-1:0]      reg2ip_ack_i,
  input  logic [NUM_CH*DW-1:0]   ip2reg_data_i,
  input  logic [NUM_CH-1:0]      ip2reg_valid_i
);

  localparam int WW = AW - 2;
  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  // Only the error field of STATUS may be written (W1C); anything else is rejected.
  localparam logic [31:0] ERR_MASK = 32'(((1 << NUM_CH) - 1) << 8);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, DONE} state_t;

  state_t                state_q;
  logic [NUM_CH*DW-1:0]  wdata_q;
  logic [NUM_CH*DW-1:0]  rdata_q;
  logic [NUM_CH-1:0]     valid_q;
  logic [NUM_CH-1:0]     err_q;
  logic [NUM_CH-1:0]     en_q;      // one-hot: also records which channel is in flight
  logic [CW-1:0]         cnt_q;
  logic [31:0]           prdata_q;
  logic                  pready_q;
  logic                  pslverr_q;

  logic [WW-1:0]         word;
  logic [2:0]            idx;
  logic                  access;
  logic                  sel_wdata;
  logic                  sel_rdata;
  logic                  sel_status;
  logic                  acc_err;
  logic [31:0]           rd_mux;
  logic [NUM_CH-1:0]     rd_clr;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^apb.paddr[1:0];

  // Address decode, read mux and legality check for the access seen in IDLE.
  always_comb begin
    word       = apb.paddr[AW-1:2];
    idx        = word[2:0];
    access     = (state_q == IDLE) && apb.psel && apb.penable;
    sel_wdata  = word < WW'(NUM_CH);
    sel_rdata  = (word >= WW'(16)) && (word < WW'(16 + NUM_CH));
    sel_status = word == WW'(32);
    rd_mux     = '0;
    acc_err    = 1'b0;
    rd_clr     = '0;
    if (sel_wdata) begin
      rd_mux[DW-1:0] = wdata_q[int'(idx)*DW +: DW];
    end else if (sel_rdata) begin
      rd_mux[DW-1:0] = rdata_q[int'(idx)*DW +: DW];
    end else if (sel_status) begin
      rd_mux[NUM_CH-1:0]  = valid_q;
      rd_mux[8 +: NUM_CH] = err_q;
    end
    if (apb.pwrite) begin
      acc_err = !(sel_wdata || (sel_status && ((apb.pwdata & ~ERR_MASK) == '0)));
    end else begin
      acc_err = !(sel_wdata || sel_rdata || sel_status);
    end
    if (access && !apb.pwrite && sel_rdata) begin
      rd_clr = NUM_CH'(1) << idx;
    end
  end

  // Transfer FSM: owns WDATA, the write strobes, the timeout counter, STATUS.err and the APB response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      wdata_q   <= '0;
      err_q     <= '0;
      en_q      <= '0;
      cnt_q     <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access) begin
            if (acc_err) begin
              prdata_q  <= '0;
              pslverr_q <= 1'b1;
              pready_q  <= 1'b1;
              state_q   <= DONE;
            end else if (apb.pwrite && sel_wdata) begin
              wdata_q[int'(idx)*DW +: DW] <= apb.pwdata[DW-1:0];
              en_q     <= NUM_CH'(1) << idx;
              cnt_q    <= '0;
              prdata_q <= '0;
              state_q  <= WAIT_ACK;
            end else begin
              // W1C on err; a timeout cannot land in IDLE, so there is no set/clear race here.
              if (apb.pwrite) begin
                err_q <= err_q & ~apb.pwdata[8 +: NUM_CH];
              end
              prdata_q  <= apb.pwrite ? 32'd0 : rd_mux;
              pslverr_q <= 1'b0;
              pready_q  <= 1'b1;
              state_q   <= DONE;
            end
          end
        end
        WAIT_ACK: begin
          // psel is deliberately ignored here: once strobed, the IP handshake always completes.
          if (|(reg2ip_ack_i & en_q)) begin
            en_q      <= '0;
            pslverr_q <= 1'b0;
            pready_q  <= 1'b1;
            state_q   <= DONE;
          end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST)) begin
            en_q      <= '0;
            err_q     <= err_q | en_q;
            pslverr_q <= 1'b1;
            pready_q  <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Capture path: IP read data loads RDATA every cycle; valid is sticky until a read, and a new valid wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      valid_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ip2reg_valid_i[i]) begin
          rdata_q[i*DW +: DW] <= ip2reg_data_i[i*DW +: DW];
        end
      end
      valid_q <= (valid_q & ~rd_clr) | ip2reg_valid_i;
    end
  end

  assign apb.prdata    = prdata_q;
  assign apb.pready    = pready_q;
  assign apb.pslverr   = pslverr_q;
  assign reg2ip_data_o = wdata_q;
  assign reg2ip_en_o   = en_q;

endmodule

// File: tb/tb_custom_ip_reg_bridge.sv
// Directed bench for custom_ip_reg_bridge: vector table plus hand-written capture and reset sequences.
// Latency: checks exact wait-state counts and strobe lengths per transfer.
// Backpressure: an IP model acknowledges after a programmable number of strobe cycles, or never.
module tb_custom_ip_reg_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [95:0] reg2ip_data_o;
  logic [2:0]  reg2ip_en_o;
  logic [2:0]  reg2ip_ack_i = '0;
  logic [95:0] ip2reg_data_i = '0;
  logic [2:0]  ip2reg_valid_i = '0;

  int n_chk = 0;
  int n_err = 0;
  int ack_delay = 0;
  bit ack_other = 1'b0;
  int en_run = 0;

  custom_ip_reg_bridge_if #(.AW(12)) apb ();

  custom_ip_reg_bridge #(
    .NUM_CH(3), .DW(32), .AW(12), .TIMEOUT_CYC(8)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .apb            (apb),
    .reg2ip_data_o  (reg2ip_data_o),
    .reg2ip_en_o    (reg2ip_en_o),
    .reg2ip_ack_i   (reg2ip_ack_i),
    .ip2reg_data_i  (ip2reg_data_i),
    .ip2reg_valid_i (ip2reg_valid_i)
  );

  always #5 clk = ~clk;

  // IP model: ack the strobed channel in its ack_delay-th strobe cycle (0 = never), or ack only the other channels.
  always @(negedge clk) begin
    if (reg2ip_en_o != 3'b000) begin
      en_run = en_run + 1;
      if (ack_other) reg2ip_ack_i = ~reg2ip_en_o;
      else if (ack_delay > 0 && en_run == ack_delay) reg2ip_ack_i = reg2ip_en_o;
      else reg2ip_ack_i = 3'b000;
    end else begin
      en_run = 0;
      reg2ip_ack_i = 3'b000;
    end
  end

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wd;
    int          dly;
    bit          oth;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_waits;
    int          exp_en;
    logic [2:0]  exp_pat;
  } vec_t;

  vec_t vt [21];

  function automatic vec_t mk(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                              input int dly, input bit oth, input logic [31:0] exp_rd,
                              input logic exp_err, input int exp_waits, input int exp_en,
                              input logic [2:0] exp_pat);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wd = wd; v.dly = dly; v.oth = oth;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_waits = exp_waits;
    v.exp_en = exp_en; v.exp_pat = exp_pat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One APB transfer; optionally pulses ip2reg_valid in the access cycle. Reports response and strobe activity.
  task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                          input logic [2:0] vmask, input logic [31:0] vdata,
                          output logic [31:0] rd, output logic er, output int waits,
                          output int encyc, output logic [2:0] enor, output logic [95:0] endat);
    waits = 0; encyc = 0; enor = '0; endat = '0; rd = '0; er = 1'b0;
    @(posedge clk); #1;
    apb.paddr = addr; apb.pwrite = wr; apb.pwdata = wd; apb.psel = 1'b1; apb.penable = 1'b0;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    if (vmask != 3'b000) begin
      ip2reg_valid_i = vmask;
      ip2reg_data_i  = {3{vdata}};
      fork
        begin
          @(posedge clk); #1;
          ip2reg_valid_i = 3'b000;
        end
      join_none
    end
    while (1) begin
      @(negedge clk);
      if (reg2ip_en_o != 3'b000) begin
        encyc++;
        enor |= reg2ip_en_o;
        endat = reg2ip_data_o;
      end
      if (apb.pready) begin
        rd = apb.prdata;
        er = apb.pslverr;
        break;
      end
      waits++;
      if (waits > 40) begin
        n_chk++; n_err++;
        $display("FAIL pready_timeout: got no pready after %0d cycles, expected at most 40", waits);
        break;
      end
    end
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          waits, encyc;
  logic [2:0]  enor;
  logic [95:0] endat;

  initial begin
    apb.paddr = '0; apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.pwdata = '0;

    vt[0]  = mk(1, 12'h004, 32'hDEADBEEF, 3, 0, 32'h0,        0, 4, 3, 3'b010);
    vt[1]  = mk(0, 12'h004, 32'h0,        0, 0, 32'hDEADBEEF, 0, 1, 0, 3'b000);
    vt[2]  = mk(1, 12'h000, 32'h12345678, 0, 0, 32'h0,        1, 9, 8, 3'b001);
    vt[3]  = mk(0, 12'h080, 32'h0,        0, 0, 32'h100,      0, 1, 0, 3'b000);
    vt[4]  = mk(1, 12'h080, 32'h100,      0, 0, 32'h0,        0, 1, 0, 3'b000);
    vt[5]  = mk(0, 12'h080, 32'h0,        0, 0, 32'h0,        0, 1, 0, 3'b000);
    vt[6]  = mk(0, 12'h000, 32'h0,        0, 0, 32'h12345678, 0, 1, 0, 3'b000);
    vt[7]  = mk(0, 12'h03C, 32'h0,        0, 0, 32'h0,        1, 1, 0, 3'b000);
    vt[8]  = mk(1, 12'h040, 32'hFFFF,     0, 0, 32'h0,        1, 1, 0, 3'b000);
    vt[9]  = mk(1, 12'h080, 32'h1,        0, 0, 32'h0,        1, 1, 0, 3'b000);
    vt[10] = mk(1, 12'h00C, 32'h1,        0, 0, 32'h0,        1, 1, 0, 3'b000);
    vt[11] = mk(1, 12'h008, 32'hCAFE0001, 1, 0, 32'h0,        0, 2, 1, 3'b100);
    vt[12] = mk(1, 12'h008, 32'h55AA,     5, 1, 32'h0,        1, 9, 8, 3'b100);
    vt[13] = mk(0, 12'h080, 32'h0,        0, 0, 32'h400,      0, 1, 0, 3'b000);
    vt[14] = mk(1, 12'h080, 32'h401,      0, 0, 32'h0,        1, 1, 0, 3'b000);
    vt[15] = mk(0, 12'h080, 32'h0,        0, 0, 32'h400,      0, 1, 0, 3'b000);
    vt[16] = mk(1, 12'h080, 32'h400,      0, 0, 32'h0,        0, 1, 0, 3'b000);
    vt[17] = mk(0, 12'h008, 32'h0,        0, 0, 32'h55AA,     0, 1, 0, 3'b000);
    vt[18] = mk(0, 12'h040, 32'h0,        0, 0, 32'h0,        0, 1, 0, 3'b000);
    vt[19] = mk(0, 12'h084, 32'h0,        0, 0, 32'h0,        1, 1, 0, 3'b000);
    vt[20] = mk(0, 12'h080, 32'h0,        0, 0, 32'h0,        0, 1, 0, 3'b000);

    // Reset state
    #13;
    chk("rst_prdata",  96'(apb.prdata),  96'h0);
    chk("rst_pready",  96'(apb.pready),  96'h0);
    chk("rst_pslverr", 96'(apb.pslverr), 96'h0);
    chk("rst_en",      96'(reg2ip_en_o), 96'h0);
    chk("rst_data",    reg2ip_data_o,    96'h0);
    #10 rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 21; i++) begin
      ack_delay = vt[i].dly;
      ack_other = vt[i].oth;
      apb_xfer(vt[i].wr, vt[i].addr, vt[i].wd, 3'b000, 32'h0, rd, er, waits, encyc, enor, endat);
      if (!vt[i].wr) chk($sformatf("v%0d_rdata", i), 96'(rd), 96'(vt[i].exp_rd));
      chk($sformatf("v%0d_pslverr", i), 96'(er),    96'(vt[i].exp_err));
      chk($sformatf("v%0d_waits", i),   96'(waits), 96'(vt[i].exp_waits));
      chk($sformatf("v%0d_encyc", i),   96'(encyc), 96'(vt[i].exp_en));
      chk($sformatf("v%0d_enpat", i),   96'(enor),  96'(vt[i].exp_pat));
      if (i == 0) chk("v0_strobe_data", 96'(endat[63:32]), 96'hDEADBEEF);
    end
    ack_other = 1'b0;
    chk("wdata_all", reg2ip_data_o, {32'h55AA, 32'hDEADBEEF, 32'h12345678});

    // Capture on channel 2, sticky valid cleared by the read
    @(posedge clk); #1;
    ip2reg_valid_i = 3'b100; ip2reg_data_i = {32'h48D0, 64'h0};
    @(posedge clk); #1;
    ip2reg_valid_i = 3'b000;
    apb_xfer(0, 12'h080, 0, 3'b000, 0, rd, er, waits, encyc, enor, endat);
    chk("cap_status_set", 96'(rd), 96'h004);
    apb_xfer(0, 12'h048, 0, 3'b000, 0, rd, er, waits, encyc, enor, endat);
    chk("cap_rdata2", 96'(rd), 96'h48D0);
    apb_xfer(0, 12'h080, 0, 3'b000, 0, rd, er, waits, encyc, enor, endat);
    chk("cap_status_clr", 96'(rd), 96'h000);

    // Read of RDATA[0] racing a new valid: old data returned, valid stays set
    @(posedge clk); #1;
    ip2reg_valid_i = 3'b001; ip2reg_data_i = {64'h0, 32'h1111};
    @(posedge clk); #1;
    ip2reg_valid_i = 3'b000;
    apb_xfer(0, 12'h040, 0, 3'b001, 32'h2468, rd, er, waits, encyc, enor, endat);
    chk("race_old_data", 96'(rd), 96'h1111);
    apb_xfer(0, 12'h080, 0, 3'b000, 0, rd, er, waits, encyc, enor, endat);
    chk("race_valid_kept", 96'(rd), 96'h001);
    apb_xfer(0, 12'h040, 0, 3'b000, 0, rd, er, waits, encyc, enor, endat);
    chk("race_new_data", 96'(rd), 96'h2468);
    apb_xfer(0, 12'h080, 0, 3'b000, 0, rd, er, waits, encyc, enor, endat);
    chk("race_valid_clr", 96'(rd), 96'h000);

    // Reset pulsed while a write waits for an ack that never comes
    ack_delay = 0;
    @(posedge clk); #1;
    apb.paddr = 12'h004; apb.pwrite = 1'b1; apb.pwdata = 32'hA5A5A5A5; apb.psel = 1'b1; apb.penable = 1'b0;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_en_high", 96'(reg2ip_en_o), 96'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_en",     96'(reg2ip_en_o), 96'h0);
    chk("mid_rst_pready", 96'(apb.pready),  96'h0);
    chk("mid_rst_data",   reg2ip_data_o,    96'h0);
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ack_delay = 2;
    apb_xfer(1, 12'h004, 32'h77, 3'b000, 0, rd, er, waits, encyc, enor, endat);
    chk("post_rst_pslverr", 96'(er),    96'h0);
    chk("post_rst_waits",   96'(waits), 96'h3);
    chk("post_rst_encyc",   96'(encyc), 96'h2);
    chk("post_rst_enpat",   96'(enor),  96'h2);
    chk("post_rst_data",    reg2ip_data_o, {32'h0, 32'h77, 32'h0});
    apb_xfer(0, 12'h080, 0, 3'b000, 0, rd, er, waits, encyc, enor, endat);
    chk("post_rst_status",  96'(rd), 96'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
